uni_stream_decode: RTL and testbench

Windowed bitstream-to-binary decoder for unary/stochastic streams such as the quotient of the gated divider. Counts ones in the stream over a window of 2^DEP valid bits and emits the result as a binary word through a valid/ready output, in unipolar (ones count) or bipolar (2·ones − 2^DEP) format. It sits at the output end of a unary kernel chain, feeding binary consumers and the accuracy checker.

---
 rtl/uni_stream_decode_pkg.sv | 19 +
 rtl/uni_stream_decode.sv | 156 +++++++++++++++
 tb/tb_uni_stream_decode.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uni_stream_decode_pkg.sv
// ---------------------------------------------------------------------------
// uni_stream_decode_pkg
// Shared definitions for the unary stream decoder:
//   state_e    : decoder FSM states (IDLE, RUN)
//   res_width  : width of the binary result for a window of 2^dep bits.
//                Covers 0..N unsigned and -N..+N two's complement.
// ---------------------------------------------------------------------------
package uni_stream_decode_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int res_width(input int dep);
    return dep + 2;
  endfunction

endpackage

// File: rtl/uni_stream_decode.sv
// ---------------------------------------------------------------------------
// uni_stream_decode
// Windowed bitstream-to-binary decoder. Counts ones over a window of
// N = 2^DEP qualified bits and emits the count (unipolar) or 2*ones - N
// (bipolar) through a valid/ready output register.
//
// Parameters
//   DEP        window length exponent, N = 2^DEP
//   BIPOLAR    0: unsigned ones count, 1: signed 2*ones - N
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start_i      begin a window (IDLE only)
//   cont_i       continuous mode, sampled at window end
//   clr_i        synchronous abort: back to IDLE, pending result dropped
//   in_bit_i     stream bit
//   in_vld_i     qualifies in_bit_i
//   busy_o       high while in RUN
//   out_data_o   result, DEP+2 bits
//   out_vld_o    result pending
//   out_rdy_i    consumer ready
//   overrun_o    one-cycle pulse when a finished result was discarded
//   state_o      current FSM state (debug)
//
// Handshake: a transfer happens on every rising clock edge where
// out_vld_o & out_rdy_i are both high. While out_vld_o is high and
// out_rdy_i is low, out_data_o is held stable. out_rdy_i is ignored while
// out_vld_o is low.
// ---------------------------------------------------------------------------
module uni_stream_decode
  import uni_stream_decode_pkg::*;
#(
  parameter int DEP     = 5,
  parameter int BIPOLAR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      cont_i,
  input  logic                      clr_i,
  input  logic                      in_bit_i,
  input  logic                      in_vld_i,
  output logic                      busy_o,
  output logic [res_width(DEP)-1:0] out_data_o,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic                      overrun_o,
  output state_e                    state_o
);

  localparam int          RW      = res_width(DEP);
  localparam int unsigned N       = 1 << DEP;
  localparam logic [DEP-1:0] CNT_ONE = {{(DEP-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]  BIAS    = RW'(N);

  state_e           state_q;
  logic [DEP-1:0]   win_cnt_q;
  logic [DEP:0]     ones_q;
  logic [RW-1:0]    out_data_q;
  logic             out_vld_q;
  logic             overrun_q;

  logic [DEP:0]     ones_d;
  logic [RW-1:0]    result_d;
  logic             win_end;
  logic             load;

  // Count including the current bit; the final bit of a window belongs to it.
  // ones never exceeds N, so DEP+1 bits cannot wrap.
  assign ones_d  = ones_q + {{DEP{1'b0}}, in_bit_i};

  // Window end: last qualified bit of the window while running.
  assign win_end = (state_q == ST_RUN) && in_vld_i && (&win_cnt_q);

  // New result may enter the output register if it is empty or is being
  // drained in this same cycle (back-to-back transfer).
  assign load    = win_end && (!out_vld_q || out_rdy_i);

  generate
    if (BIPOLAR != 0) begin : g_bipolar
      // (ones << 1) - N in DEP+2 bits: -N..+N two's complement.
      assign result_d = {ones_d, 1'b0} - BIAS;
    end else begin : g_unipolar
      assign result_d = {1'b0, ones_d};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      ones_q     <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (clr_i) begin
      // Abort: out_data_q is left as is, it is meaningless without out_vld.
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      ones_q     <= '0;
      out_vld_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      // Drain; a load below in the same cycle overrides this.
      if (out_vld_q && out_rdy_i) begin
        out_vld_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_RUN;
            win_cnt_q <= '0;
            ones_q    <= '0;
          end
        end

        ST_RUN: begin
          if (in_vld_i) begin
            if (win_end) begin
              // The next qualified bit starts a fresh window.
              win_cnt_q <= '0;
              ones_q    <= '0;
              if (load) begin
                out_data_q <= result_d;
                out_vld_q  <= 1'b1;
              end else begin
                overrun_q  <= 1'b1;
              end
              if (!cont_i) begin
                state_q <= ST_IDLE;
              end
            end else begin
              win_cnt_q <= win_cnt_q + CNT_ONE;
              ones_q    <= ones_d;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign out_data_o = out_data_q;
  assign out_vld_o  = out_vld_q;
  assign overrun_o  = overrun_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uni_stream_decode.sv
// ---------------------------------------------------------------------------
// tb_uni_stream_decode
// Two decoders (unipolar and bipolar, DEP=5) share one stimulus stream.
// A reference model collects qualified bits into a window queue, sums them
// when the window holds N bits, and pushes the expected results into
// scoreboard queues. A monitor on the falling edge compares outputs.
// ---------------------------------------------------------------------------
module tb_uni_stream_decode;
  import uni_stream_decode_pkg::*;

  localparam int DEP = 5;
  localparam int N   = 32;
  localparam int RW  = DEP + 2;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared inputs
  logic start = 1'b0, cont = 1'b0, clr = 1'b0;
  logic in_bit = 1'b0, in_vld = 1'b0, out_rdy = 1'b0;

  // Outputs
  logic          busy_u, busy_b, vld_u, vld_b, ovr_u, ovr_b;
  logic [RW-1:0] data_u, data_b;
  state_e        state_u, state_b;

  uni_stream_decode #(.DEP(DEP), .BIPOLAR(0)) u_uni (
    .clk(clk), .rst_n(rst_n), .start_i(start), .cont_i(cont), .clr_i(clr),
    .in_bit_i(in_bit), .in_vld_i(in_vld), .busy_o(busy_u),
    .out_data_o(data_u), .out_vld_o(vld_u), .out_rdy_i(out_rdy),
    .overrun_o(ovr_u), .state_o(state_u)
  );

  uni_stream_decode #(.DEP(DEP), .BIPOLAR(1)) u_bip (
    .clk(clk), .rst_n(rst_n), .start_i(start), .cont_i(cont), .clr_i(clr),
    .in_bit_i(in_bit), .in_vld_i(in_vld), .busy_o(busy_b),
    .out_data_o(data_b), .out_vld_o(vld_b), .out_rdy_i(out_rdy),
    .overrun_o(ovr_b), .state_o(state_b)
  );

  // Scoreboard
  logic [RW-1:0] exp_u_q[$];
  logic [RW-1:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: window as a queue of bits, result = sum of the bits.
  logic win_bits[$];
  bit   m_run, m_pend, m_ovr;

  always @(posedge clk or negedge rst_n) begin : model
    int  s;
    bit  ld;
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_ovr = 0;
      win_bits.delete(); exp_u_q.delete(); exp_b_q.delete();
    end else if (clr) begin
      m_run = 0; m_pend = 0; m_ovr = 0;
      win_bits.delete(); exp_u_q.delete(); exp_b_q.delete();
    end else begin
      ld    = 0;
      m_ovr = 0;
      if (m_run) begin
        if (in_vld) begin
          win_bits.push_back(in_bit);
          if (win_bits.size() == N) begin
            s = 0;
            foreach (win_bits[i]) s += int'(win_bits[i]);
            if (!m_pend || out_rdy) begin
              ld = 1;
              exp_u_q.push_back(RW'(s));
              exp_b_q.push_back(RW'(2 * s - N));
            end else begin
              m_ovr = 1;
            end
            win_bits.delete();
            if (!cont) m_run = 0;
          end
        end
      end else if (start) begin
        m_run = 1;
        win_bits.delete();
      end
      if (ld) m_pend = 1;
      else if (m_pend && out_rdy) m_pend = 0;
    end
  end

  // Monitor: compare on the falling edge, pop on an accepted transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_u", busy_u, m_run);
      chk("busy_b", busy_b, m_run);
      chk("state_u", state_u, m_run ? ST_RUN : ST_IDLE);
      chk("vld_u", vld_u, m_pend);
      chk("vld_b", vld_b, m_pend);
      chk("ovr_u", ovr_u, m_ovr);
      chk("ovr_b", ovr_b, m_ovr);
      if (vld_u) begin
        if (exp_u_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("data_u", data_u, exp_u_q[0]);
          chk("data_b", data_b, exp_b_q[0]);
          if (out_rdy) begin
            void'(exp_u_q.pop_front());
            void'(exp_b_q.pop_front());
          end
        end
      end
    end
  end

  // Driver tasks
  bit rand_rdy = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  endtask

  // The start cycle carries a valid 1 that must not be counted in IDLE.
  task automatic start_win();
    start = 1; in_vld = 1; in_bit = 1;
    cyc();
    start = 0; in_vld = 0; in_bit = 0;
  endtask

  // Send n qualified bits pat[0..n-1], with random gaps of gap_pct percent.
  task automatic send(input logic [31:0] pat, input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_vld = 0; in_bit = 1'($urandom_range(0, 1));
        cyc();
      end
      in_vld = 1; in_bit = pat[i];
      cyc();
    end
    in_vld = 0; in_bit = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_clr();
    clr = 1; cyc(); clr = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy_u, 0);
    chk("rst_vld", vld_u, 0);
    chk("rst_data_u", data_u, 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_ovr", ovr_u, 0);
    chk("rst_state", state_u, ST_IDLE);
    rst_n = 1;
    cyc();

    // Single windows, cont=0, consumer ready
    out_rdy = 1;
    start_win(); send(32'hFFFF_FFFF, 32, 0); idle(3);   // 32 / +32
    start_win(); send(32'h0000_0000, 32, 0); idle(3);   // 0 / -32
    start_win(); send(32'h5555_5555, 32, 0); idle(3);   // 16 / 0
    start_win(); send(32'h00FF_FFFF, 32, 0); idle(3);   // 24 / +16

    // Gapped window aborted by clr, then a clean window
    start_win();
    for (int i = 0; i < 20; i++) begin
      in_vld = 1; in_bit = 1; cyc();
      in_vld = 0; in_bit = 1; cyc();
    end
    in_vld = 0; in_bit = 0;
    pulse_clr();
    #3;
    chk("clr_state", state_u, ST_IDLE);
    chk("clr_vld", vld_u, 0);
    start_win(); send(32'hFFFF_FFFF, 32, 0); idle(3);

    // cont, consumer stalled: second result dropped with overrun
    out_rdy = 0; cont = 1;
    start_win(); send(32'h0000_FFFF, 32, 0); send(32'hFFFF_FFFF, 32, 0);
    idle(4);
    out_rdy = 1; idle(2);
    cont = 0;
    pulse_clr(); idle(2);

    // cont, consumer ready: three back-to-back windows
    out_rdy = 1; cont = 1;
    start_win();
    send(32'h0000_00FF, 32, 0);
    send(32'h0000_FFFF, 32, 0);
    cont = 0;
    send(32'hFFFF_FFFF, 32, 0);
    idle(3);

    // Randomized windows, gaps and back-pressure
    rand_rdy = 1;
    for (int w = 0; w < 20; w++) begin
      cont = 1'($urandom_range(0, 1));
      start_win();
      send($urandom, 32, $urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) pulse_clr();
      idle($urandom_range(0, 3));
    end
    cont = 0; rand_rdy = 0; out_rdy = 1;
    pulse_clr(); idle(3);

    // Asynchronous reset mid-window
    start_win(); send(32'hFFFF_FFFF, 32, 0); idle(1);
    start_win(); send(32'h0000_03FF, 10, 0);
    rst_n = 0;
    #1;
    chk("arst_busy", busy_u, 0);
    chk("arst_vld", vld_u, 0);
    chk("arst_data_u", data_u, 0);
    chk("arst_data_b", data_b, 0);
    chk("arst_ovr", ovr_u, 0);
    chk("arst_state", state_b, ST_IDLE);
    cyc();
    rst_n = 1;
    send(32'hFFFF_FFFF, 32, 0);
    send(32'hFFFF_FFFF, 8, 0);
    idle(2);
    start_win(); send(32'hFFFF_FFFF, 32, 0);

    // Drain with a bounded wait
    begin
      int budget;
      budget = 200;
      while ((exp_u_q.size() != 0 || m_pend) && budget > 0) begin
        cyc(); budget--;
      end
      chk("drain_timeout", (budget == 0) ? 1 : 0, 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
